// File: rtl/split_target_unit_pkg.sv
// Shared types and widths for the split-transaction serial target.
// States, address width and data width used by the top level and the memory core.
package split_target_unit_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      WDATA,
      RWAIT,
      SREQ,
      SEND
   } state_t;

endpackage

// File: rtl/split_target_core.sv
// Memory/latency core: byte memory with in-place writes, registered read into a
// holding register, and the read-latency counter that paces the return.
module split_target_core
   import split_target_unit_pkg::*;
#(
   parameter int MEM_DEPTH    = 256,
   parameter int READ_LATENCY = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic                         rd_en,
   input  logic                         lat_start,
   input  logic                         lat_run,
   input  logic [$clog2(MEM_DEPTH)-1:0] index,
   input  logic [DATA_W-1:0]            wr_data,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         lat_done
);

   localparam int LAT_W = $clog2(READ_LATENCY + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [LAT_W-1:0]  lat_cnt_reg;

   // Memory contents survive reset on purpose; only the read path is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[index] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[index];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_cnt_reg <= '0;
      end else if (lat_start) begin
         lat_cnt_reg <= '0;
      end else if (lat_run && !lat_done) begin
         lat_cnt_reg <= lat_cnt_reg + 1'b1;
      end
   end

   assign lat_done = (lat_cnt_reg == LAT_LAST);

endmodule

// File: rtl/split_target_unit.sv
// Serial-bus target with split reads: shift registers, state machine, arbiter handshake.
// Define SPLIT_TARGET_SPLIT_EN for split reads; otherwise reads hold the bus until data is sent.
module split_target_unit
   import split_target_unit_pkg::*;
#(
   parameter int MEM_DEPTH    = 256,
   parameter int READ_LATENCY = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic bus_data_in,
   input  logic bus_data_in_valid,
   input  logic bus_mode,
   input  logic bus_rw,
   input  logic split_grant,
   output logic bus_data_out,
   output logic bus_data_out_valid,
   output logic arbiter_split_req,
   output logic bus_split_ack,
   output logic bus_target_ack,
   output logic bus_target_rw,
   output logic bus_target_ready
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   state_t              state_reg;
   logic [3:0]          bit_cnt_reg;
   logic [IDX_W-1:0]    addr_reg;
   logic [DATA_W-2:0]   data_reg;
   logic [DATA_W-1:0]   hold_data;
   logic [DATA_W-1:0]   wr_data;
   logic                addr_bit;
   logic                data_bit;
   logic                wr_en;
   logic                lat_start;
   logic                lat_run;
   logic                lat_done;

   assign addr_bit  = bus_data_in_valid && !bus_mode;
   assign data_bit  = bus_data_in_valid && bus_mode;
   assign lat_start = (state_reg == IDLE) && addr_bit && (bit_cnt_reg == 4'd15) && !bus_rw;
   assign lat_run   = (state_reg == RWAIT);
   assign wr_en     = (state_reg == WDATA) && data_bit && (bit_cnt_reg[2:0] == 3'd7);
   assign wr_data   = {bus_data_in, data_reg};

   // Upper address bits only alias onto the same cell, so just the index bits are kept.
   for (genvar gi = 0; gi < IDX_W; gi++) begin : g_addr
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            addr_reg[gi] <= 1'b0;
         end else if ((state_reg == IDLE) && addr_bit && (bit_cnt_reg == 4'(gi))) begin
            addr_reg[gi] <= bus_data_in;
         end
      end
   end

   split_target_core #(
      .MEM_DEPTH    (MEM_DEPTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .rd_en     (lat_run),
      .lat_start (lat_start),
      .lat_run   (lat_run),
      .index     (addr_reg),
      .wr_data   (wr_data),
      .rd_data   (hold_data),
      .lat_done  (lat_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg          <= IDLE;
         bit_cnt_reg        <= '0;
         data_reg           <= '0;
         bus_data_out       <= 1'b0;
         bus_data_out_valid <= 1'b0;
         arbiter_split_req  <= 1'b0;
         bus_split_ack      <= 1'b0;
         bus_target_ack     <= 1'b0;
         bus_target_rw      <= 1'b0;
         bus_target_ready   <= 1'b1;
      end else begin
         bus_split_ack  <= 1'b0;
         bus_target_ack <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (addr_bit) begin
                  if (bit_cnt_reg == 4'd15) begin
                     bit_cnt_reg      <= '0;
                     bus_target_rw    <= bus_rw;
                     bus_target_ready <= 1'b0;
                     if (bus_rw) begin
                        state_reg <= WDATA;
                     end else begin
                        state_reg <= RWAIT;
`ifdef SPLIT_TARGET_SPLIT_EN
                        bus_split_ack <= 1'b1;
`endif
                     end
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                  end
               end
            end
            WDATA: begin
               if (data_bit) begin
                  if (bit_cnt_reg[2:0] == 3'd7) begin
                     bit_cnt_reg      <= '0;
                     bus_target_ack   <= 1'b1;
                     bus_target_ready <= 1'b1;
                     state_reg        <= IDLE;
                  end else begin
                     data_reg[bit_cnt_reg[2:0]] <= bus_data_in;
                     bit_cnt_reg                <= bit_cnt_reg + 4'd1;
                  end
               end
            end
            RWAIT: begin
               if (lat_done) begin
`ifdef SPLIT_TARGET_SPLIT_EN
                  state_reg         <= SREQ;
                  arbiter_split_req <= 1'b1;
`else
                  // Bus is still held; SEND begins with bit 0 on the following edge.
                  state_reg   <= SEND;
                  bit_cnt_reg <= '0;
`endif
               end
            end
            SREQ: begin
               if (split_grant) begin
                  arbiter_split_req  <= 1'b0;
                  bus_data_out       <= hold_data[0];
                  bus_data_out_valid <= 1'b1;
                  bit_cnt_reg        <= 4'd1;
                  state_reg          <= SEND;
               end
            end
            SEND: begin
               if (bit_cnt_reg == 4'd8) begin
                  bus_data_out       <= 1'b0;
                  bus_data_out_valid <= 1'b0;
                  bus_target_ack     <= 1'b1;
                  bus_target_ready   <= 1'b1;
                  bit_cnt_reg        <= '0;
                  state_reg          <= IDLE;
               end else begin
                  bus_data_out       <= hold_data[bit_cnt_reg[2:0]];
                  bus_data_out_valid <= 1'b1;
                  bit_cnt_reg        <= bit_cnt_reg + 4'd1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_split_target_unit.sv
// Scoreboard bench for split_target_unit: stimulus queues expected acks/bytes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_split_target_unit;

   localparam int MEM_DEPTH    = 256;
   localparam int READ_LATENCY = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bus_data_in = 1'b0;
   logic bus_data_in_valid = 1'b0;
   logic bus_mode = 1'b0;
   logic bus_rw = 1'b0;
   logic split_grant = 1'b0;
   logic bus_data_out;
   logic bus_data_out_valid;
   logic arbiter_split_req;
   logic bus_split_ack;
   logic bus_target_ack;
   logic bus_target_rw;
   logic bus_target_ready;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic       exp_ack_q  [$];
   logic [7:0] exp_byte_q [$];
   bit split_seen = 1'b0;

   split_target_unit #(
      .MEM_DEPTH    (MEM_DEPTH),
      .READ_LATENCY (READ_LATENCY)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .bus_data_in        (bus_data_in),
      .bus_data_in_valid  (bus_data_in_valid),
      .bus_mode           (bus_mode),
      .bus_rw             (bus_rw),
      .split_grant        (split_grant),
      .bus_data_out       (bus_data_out),
      .bus_data_out_valid (bus_data_out_valid),
      .arbiter_split_req  (arbiter_split_req),
      .bus_split_ack      (bus_split_ack),
      .bus_target_ack     (bus_target_ack),
      .bus_target_rw      (bus_target_rw),
      .bus_target_ready   (bus_target_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic v, input logic m, input logic d, input logic rw);
      @(negedge clk);
      bus_data_in_valid = v;
      bus_mode          = m;
      bus_data_in       = d;
      bus_rw            = rw;
   endtask

   // which: 0 = ready high, 1 = split request high, 2 = data valid high
   task automatic wait_sig(input int which, input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         case (which)
            0: seen = bus_target_ready;
            1: seen = arbiter_split_req;
            default: seen = bus_data_out_valid;
         endcase
      end
      check(name, 32'(seen), 32'd1);
   endtask

   task automatic send_addr(input logic [15:0] a, input logic rw, input bit gaps);
      for (int i = 0; i < 16; i++) begin
         if (gaps && (i % 5 == 2)) begin
            drive(1'b0, 1'b0, 1'b0, rw);
            drive(1'b1, 1'b1, ~a[i], rw);
         end
         drive(1'b1, 1'b0, a[i], rw);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("ready_low_after_addr", 32'(bus_target_ready), 32'd0);
   endtask

   task automatic send_data(input logic [7:0] d);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, d[i], 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit gaps);
      exp_ack_q.push_back(1'b1);
      send_addr(a, 1'b1, gaps);
      send_data(d);
      wait_sig(0, "write_ready_return");
      $display("write addr=%04h data=%02h", a, d);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [7:0] e, input int gdly,
                          input bit gaps, input bit abort);
      bit no_valid;
      if (!abort) begin
         exp_byte_q.push_back(e);
         exp_ack_q.push_back(1'b0);
      end
      send_addr(a, 1'b0, gaps);
`ifdef SPLIT_TARGET_SPLIT_EN
      wait_sig(1, "split_req_rise");
      no_valid = 1'b1;
      repeat (gdly) begin
         @(negedge clk);
         if (bus_data_out_valid) no_valid = 1'b0;
      end
      check("req_held_until_grant", 32'(arbiter_split_req), 32'd1);
      check("no_data_before_grant", 32'(no_valid), 32'd1);
      @(negedge clk) split_grant = 1'b1;
      @(negedge clk) split_grant = 1'b0;
`else
      no_valid = (gdly >= 0);
`endif
      if (abort) begin
         wait_sig(2, "send_started");
         @(negedge clk);
         @(negedge clk);
         rst = 1'b1;
         #1;
         check("abort_ready",     32'(bus_target_ready),   32'd1);
         check("abort_valid",     32'(bus_data_out_valid), 32'd0);
         check("abort_req",       32'(arbiter_split_req),  32'd0);
         check("abort_target_rw", 32'(bus_target_rw),      32'd0);
         check("abort_data_out",  32'(bus_data_out),       32'd0);
         @(negedge clk);
         @(negedge clk) rst = 1'b0;
         $display("read addr=%04h aborted by reset", a);
      end else begin
         wait_sig(0, "read_ready_return");
         $display("read addr=%04h expect=%02h grant_delay=%0d gaps=%0d", a, e, gdly, gaps);
      end
   endtask

   // Monitor: compares completions and serial bytes against the queues.
   initial begin
      logic [7:0] byte_acc = '0;
      int  nbits = 0;
      bit  gap = 1'b0;
      logic ack_prev = 1'b0, sa_prev = 1'b0, req_prev = 1'b0;
      int  sa_cyc = 0;
      logic       e_rw;
      logic [7:0] e_byte;
      forever begin
         @(negedge clk);
         if (rst) begin
            nbits = 0; gap = 1'b0;
            ack_prev = 1'b0; sa_prev = 1'b0; req_prev = 1'b0;
         end else begin
            if (bus_data_out_valid) begin
               byte_acc[nbits[2:0]] = bus_data_out;
               nbits++;
               if (nbits == 8) begin
                  check("byte_expected", 32'(exp_byte_q.size() > 0), 32'd1);
                  if (exp_byte_q.size() > 0) begin
                     e_byte = exp_byte_q.pop_front();
                     check("read_byte", 32'(byte_acc), 32'(e_byte));
                  end
                  check("consecutive_valid", 32'(gap), 32'd0);
                  nbits = 0; gap = 1'b0;
               end
            end else if (nbits != 0) begin
               gap = 1'b1;
            end
            if (bus_target_ack) begin
               check("ack_expected", 32'(exp_ack_q.size() > 0), 32'd1);
               if (exp_ack_q.size() > 0) begin
                  e_rw = exp_ack_q.pop_front();
                  check("ack_rw", 32'(bus_target_rw), 32'(e_rw));
                  check("ack_ready", 32'(bus_target_ready), 32'd1);
               end
               if (ack_prev) check("ack_one_cycle", 32'(ack_prev), 32'd0);
            end
`ifdef SPLIT_TARGET_SPLIT_EN
            if (bus_split_ack) begin
               check("split_ack_one_cycle", 32'(sa_prev), 32'd0);
               sa_cyc = cyc;
            end
            if (arbiter_split_req && !req_prev) begin
               check("req_latency", 32'(cyc - sa_cyc), 32'(READ_LATENCY));
            end
`else
            if (bus_split_ack || arbiter_split_req) split_seen = 1'b1;
`endif
            ack_prev = bus_target_ack;
            sa_prev  = bus_split_ack;
            req_prev = arbiter_split_req;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_ready",     32'(bus_target_ready),   32'd1);
      check("reset_valid",     32'(bus_data_out_valid), 32'd0);
      check("reset_req",       32'(arbiter_split_req),  32'd0);
      check("reset_split_ack", 32'(bus_split_ack),      32'd0);
      check("reset_ack",       32'(bus_target_ack),     32'd0);
      check("reset_rw",        32'(bus_target_rw),      32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      do_write(16'h8F20, 8'hC5, 1'b0);
      do_read (16'h8F20, 8'hC5, 2, 1'b0, 1'b0);
      do_write(16'h0120, 8'h3A, 1'b0);
      do_read (16'h8F20, 8'h3A, 2, 1'b0, 1'b0);
      do_read (16'h8F20, 8'h3A, 50, 1'b0, 1'b0);
      do_write(16'hABCD, 8'h5E, 1'b1);
      do_read (16'h00CD, 8'h5E, 1, 1'b1, 1'b0);
      do_read (16'h0120, 8'h3A, 0, 1'b0, 1'b1);
      do_write(16'h0001, 8'h81, 1'b0);
      do_read (16'h0001, 8'h81, 3, 1'b0, 1'b0);
      do_read (16'h7720, 8'h3A, 0, 1'b1, 1'b0);

      repeat (5) @(negedge clk);
      check("ack_queue_drained",  32'(exp_ack_q.size()),  32'd0);
      check("byte_queue_drained", 32'(exp_byte_q.size()), 32'd0);
`ifndef SPLIT_TARGET_SPLIT_EN
      check("no_split_signals", 32'(split_seen), 32'd0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/split_target_unit.md
# split_target_unit

Serial-bus target node that accepts bit-serial address and data, holds a local byte memory, and answers reads as split transactions. It combines a memory/latency core with a bus-side port. Writes complete in place. Reads release the bus with a split acknowledge, wait the memory latency, then request the bus back from the arbiter and stream the byte out serially.

## Interface
- MEM_DEPTH, 256: memory bytes; power of two; index = addr[$clog2(MEM_DEPTH)-1:0].
- READ_LATENCY, 4: cycles between read address capture and arbiter request; must be ≥1.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bus_data_in  in  1  serial bit, LSB first.
- bus_data_in_valid  in  1  bus_data_in valid this cycle.
- bus_mode  in  1  0 = address bit, 1 = data bit.
- bus_rw  in  1  transaction direction (1 = write), sampled with the 16th address bit.
- split_grant  in  1  one-cycle grant pulse from the arbiter.
- bus_data_out  out  1  serial read bit, LSB first.
- bus_data_out_valid  out  1  bus_data_out valid.
- arbiter_split_req  out  1  level request for bus return.
- bus_split_ack  out  1  one-cycle split acknowledge.
- bus_target_ack  out  1  one-cycle completion pulse.
- bus_target_rw  out  1  latched direction of the current or last transaction.
- bus_target_ready  out  1  1 = idle, accepting a new address.

## Operation
- States: IDLE (collect address), WDATA, RWAIT, SREQ, SEND.
- IDLE: on valid mode-0 bits, shift into a 16-bit address register, bit i = i-th valid bit. Mode-1 bits are ignored. Gaps in valid are allowed.
- When the 16th address bit arrives, latch bus_rw into bus_target_rw. Go to WDATA if write, RWAIT if read.
- WDATA: collect 8 valid mode-1 bits; mode-0 bits are ignored. On the 8th bit, write mem[index] and pulse bus_target_ack. Return to IDLE.
- RWAIT: pulse bus_split_ack, read mem[index] into a holding register, count READ_LATENCY cycles, then go to SREQ.
- SREQ: assert arbiter_split_req until split_grant is sampled high, then go to SEND.
- SEND: output 8 bits LSB first with bus_data_out_valid high on 8 consecutive cycles. Then pulse bus_target_ack (bus_target_rw=0) and go to IDLE.
- Bus input outside the expected phase is ignored; no error is raised.
- split_grant outside SREQ is ignored.
- Memory is not reset. A read of an unwritten location returns unspecified data.
- Reset mid-operation aborts the transaction, clears counters and returns to IDLE.

## Timing
- Reset values: bus_target_ready=1; all other outputs 0.
- bus_target_ready is 0 from the edge capturing the 16th address bit until the edge issuing bus_target_ack.
- Write: the edge sampling the 8th data bit commits the memory write and raises bus_target_ack for exactly one cycle.
- Read: the edge sampling the 16th address bit raises bus_split_ack for one cycle. arbiter_split_req rises READ_LATENCY cycles after bus_split_ack rises.
- The edge sampling split_grant drops arbiter_split_req and drives bit 0 with valid. Bits 1..7 follow on consecutive edges.
- The edge after bit 7 drops valid and raises bus_target_ack for one cycle.
- All outputs are registered.

## Configuration
- SPLIT_TARGET_SPLIT_EN defined: split read behaviour as above.
- SPLIT_TARGET_SPLIT_EN undefined: reads never assert bus_split_ack or arbiter_split_req. After READ_LATENCY cycles the block goes directly to SEND, with bus_target_ready held 0 throughout. Writes are unchanged.

## Structure
- Package split_target_unit_pkg: state enum, ADDR_W=16, DATA_W=8 constants.
- Sub-module split_target_core: memory array, write path, READ_LATENCY counter, read holding register.
- The top level holds the serial shift registers, state machine and arbiter handshake.

## Test plan
- Write 0xC5 to 0x8F20 (rw=1, 16 address bits then 8 data bits) -> exactly one bus_target_ack with bus_target_rw=1; bus_target_ready returns to 1.
- Read 0x8F20 with the arbiter granting 2 cycles after request -> one bus_split_ack; arbiter_split_req READ_LATENCY cycles later; serial out 0xC5 LSB first; one read ack with rw=0.
- Aliasing: write 0x3A to 0x0120, read 0x8F20 -> serial out 0x3A (index 0x20).
- Hold split_grant low for 50 cycles -> arbiter_split_req stays high and no data is output. A later grant completes the read normally.
- Insert valid gaps and stray mode-1 bits during the address phase -> captured address is unchanged and the transaction is correct.
- Assert rst during SEND -> outputs return to reset values immediately. The next write/read completes correctly.
